// File: rtl/ppu_pkg.sv
// Shared PPU-side types and constants used by the OAM DMA controller.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  typedef enum logic {
    GET,
    PUT
  } cpu_parity_t;

  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  localparam int          OAM_BYTES   = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer: halts the CPU and copies one CPU page into PPU OAM.
// Optional abort input and sticky aborted flag are built when OAM_DMA_ABORT_EN is defined.
module oam_dma_ctrl
  import ppu_pkg::*;
#(
  parameter int NUM_BYTES = OAM_BYTES,
  parameter bit ALIGN_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce,
  input  logic        reg_wr,
  input  logic [7:0]  reg_data,
  input  logic [7:0]  dma_data_i,
`ifdef OAM_DMA_ABORT_EN
  input  logic        abort,
  output logic        aborted,
`endif
  output logic        cpu_rdy,
  output logic        dma_rd,
  output logic [15:0] dma_addr,
  output logic [7:0]  oam_data_o,
  output logic        oam_data_wr,
  output logic        busy,
  output logic        done
);

  dma_state_t  state_q;
  cpu_parity_t parity_q;
  logic [8:0]  idx_q;
  logic [8:0]  idx_d;
  logic [7:0]  page_q;
  logic [15:0] dma_addr_q;
  logic [7:0]  oam_data_q;
  logic        cpu_rdy_q;
  logic        dma_rd_q;
  logic        busy_q;
  logic        done_q;
  logic        last_byte;
  logic        abort_now;

  assign idx_d     = idx_q + 9'd1;
  assign last_byte = (idx_q == 9'(NUM_BYTES - 1));

`ifdef OAM_DMA_ABORT_EN
  logic aborted_q;
  assign abort_now = abort;
  assign aborted   = aborted_q;
`else
  assign abort_now = 1'b0;
`endif

  // The low address byte wraps inside the page; the page byte is never touched by the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      parity_q   <= GET;
      idx_q      <= '0;
      page_q     <= '0;
      dma_addr_q <= '0;
      oam_data_q <= '0;
      cpu_rdy_q  <= 1'b1;
      dma_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef OAM_DMA_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else if (cpu_ce) begin
      parity_q <= (parity_q == GET) ? PUT : GET;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (reg_wr) begin
            page_q    <= reg_data;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            cpu_rdy_q <= 1'b0;
            state_q   <= HALT;
`ifdef OAM_DMA_ABORT_EN
            aborted_q <= 1'b0;
`endif
          end
        end
        HALT: begin
          // Current cycle GET means the following one is PUT, so the first read needs a pad.
          if (ALIGN_EN && (parity_q == GET)) begin
            state_q <= ALIGN;
          end else begin
            state_q    <= READ;
            dma_rd_q   <= 1'b1;
            dma_addr_q <= {page_q, idx_q[7:0]};
          end
        end
        ALIGN: begin
          state_q    <= READ;
          dma_rd_q   <= 1'b1;
          dma_addr_q <= {page_q, idx_q[7:0]};
        end
        READ: begin
          dma_rd_q <= 1'b0;
          if (abort_now) begin
            state_q   <= IDLE;
            cpu_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
`ifdef OAM_DMA_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else begin
            oam_data_q <= dma_data_i;
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          idx_q <= idx_d;
          if (abort_now || last_byte) begin
            state_q   <= IDLE;
            cpu_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= !abort_now;
`ifdef OAM_DMA_ABORT_EN
            aborted_q <= abort_now;
`endif
          end else begin
            state_q    <= READ;
            dma_rd_q   <= 1'b1;
            dma_addr_q <= {page_q, idx_d[7:0]};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdy     = cpu_rdy_q;
  assign dma_rd      = dma_rd_q;
  assign dma_addr    = dma_addr_q;
  assign oam_data_o  = oam_data_q;
  assign busy        = busy_q;
  // Strobes are qualified by cpu_ce so they last exactly one clk per CPU cycle.
  assign oam_data_wr = (state_q == WRITE) && cpu_ce;
  assign done        = done_q && cpu_ce;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: full-page vectors on a 256-byte instance,
// randomized short transfers on a 4-byte instance, plus reset-mid-transfer sequence.
module tb_oam_dma_ctrl;
   import ppu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic cpu_ce;
   logic reg_wr;
   logic [7:0] reg_data;
   logic [7:0] dma_data_i;
   logic [7:0] memKey;
   logic sel;

   logic rdyA, rdA, wrA, busyA, doneA;
   logic [15:0] addrA;
   logic [7:0] oamA;
   logic rdyB, rdB, wrB, busyB, doneB;
   logic [15:0] addrB;
   logic [7:0] oamB;

`ifdef OAM_DMA_ABORT_EN
   logic abort = 1'b0;
   logic abortedA, abortedB;
`endif

   always #5 clk = ~clk;

   oam_dma_ctrl dutA (
      .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .reg_wr(reg_wr), .reg_data(reg_data),
      .dma_data_i(dma_data_i),
`ifdef OAM_DMA_ABORT_EN
      .abort(abort), .aborted(abortedA),
`endif
      .cpu_rdy(rdyA), .dma_rd(rdA), .dma_addr(addrA), .oam_data_o(oamA),
      .oam_data_wr(wrA), .busy(busyA), .done(doneA)
   );

   oam_dma_ctrl #(.NUM_BYTES(4), .ALIGN_EN(1'b1)) dutB (
      .clk(clk), .rst(rst), .cpu_ce(cpu_ce), .reg_wr(reg_wr), .reg_data(reg_data),
      .dma_data_i(dma_data_i),
`ifdef OAM_DMA_ABORT_EN
      .abort(abort), .aborted(abortedB),
`endif
      .cpu_rdy(rdyB), .dma_rd(rdB), .dma_addr(addrB), .oam_data_o(oamB),
      .oam_data_wr(wrB), .busy(busyB), .done(doneB)
   );

   // The observed instance is chosen by sel; memory answers with addr low byte xor key.
   logic oRdy, oRd, oWr, oBusy, oDone;
   logic [15:0] oAddr;
   logic [7:0] oOam;
   assign oRdy  = sel ? rdyB  : rdyA;
   assign oRd   = sel ? rdB   : rdA;
   assign oWr   = sel ? wrB   : wrA;
   assign oBusy = sel ? busyB : busyA;
   assign oDone = sel ? doneB : doneA;
   assign oAddr = sel ? addrB : addrA;
   assign oOam  = sel ? oamB  : oamA;
   assign dma_data_i = oAddr[7:0] ^ memKey;

   int checks = 0;
   int errors = 0;

   int tickNo;
   int haltCnt, doneCnt, firstRd, lastWr, doneTick;
   logic lastRdy;
   logic [15:0] rdQ[$];
   logic [7:0] wrQ[$];

   typedef struct {
      logic [7:0] page;
      int trigPut;
      int injectAt;
      logic [7:0] injectPage;
      int expHalt;
      int expWrites;
      int expFirstRd;
   } vec_t;

   vec_t vecs[4];

   // Single comparison point: every check goes through here and steps the counters.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clearObs();
      haltCnt = 0; doneCnt = 0; firstRd = -1; lastWr = -100; doneTick = -1;
      rdQ.delete(); wrQ.delete();
   endtask

   // One CPU cycle: cpu_ce high for one clk, then gap idle clks during which outputs must hold.
   task automatic applyStimulus(input int gap, input logic wr, input logic [7:0] data);
      logic [26:0] snap;
      cpu_ce = 1'b1; reg_wr = wr; reg_data = data;
      @(negedge clk);
      lastRdy = oRdy;
      if (!oRdy) haltCnt++;
      if (oRd) begin
         rdQ.push_back(oAddr);
         if (firstRd < 0) firstRd = tickNo;
      end
      if (oWr) begin
         wrQ.push_back(oOam);
         lastWr = tickNo;
      end
      if (oDone) begin
         doneCnt++;
         doneTick = tickNo;
      end
      @(posedge clk); #1;
      cpu_ce = 1'b0; reg_wr = 1'b0;
      snap = '0;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         if (g == 0) snap = {oRdy, oRd, oBusy, oAddr, oOam};
         else checkOutput("holdBetweenCe", 32'({oRdy, oRd, oBusy, oAddr, oOam}), 32'(snap));
         checkOutput("strobesLowBetweenCe", 32'({oWr, oDone}), 32'd0);
         @(posedge clk); #1;
      end
      tickNo++;
   endtask

   task automatic doReset();
      rst = 1'b1; cpu_ce = 1'b0; reg_wr = 1'b0; reg_data = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tickNo = 0;
   endtask

   // Reference: byte k is read from {page,k} and written to OAM as k^key, in order.
   task automatic verifyTransfer(input string tag, input logic [7:0] page, input int n,
                                 input int expHalt, input int expWrites, input int expFirstRd,
                                 input int trigTick);
      checkOutput({tag, ".haltCycles"}, 32'(haltCnt), 32'(expHalt));
      checkOutput({tag, ".writeCount"}, 32'(wrQ.size()), 32'(expWrites));
      checkOutput({tag, ".readCount"}, 32'(rdQ.size()), 32'(n));
      checkOutput({tag, ".donePulses"}, 32'(doneCnt), 32'd1);
      checkOutput({tag, ".firstReadOffset"}, 32'(firstRd - trigTick), 32'(expFirstRd));
      checkOutput({tag, ".doneAfterLastWrite"}, 32'(doneTick), 32'(lastWr + 1));
      for (int k = 0; k < n && k < rdQ.size(); k++)
         checkOutput({tag, ".addr"}, 32'(rdQ[k]), 32'({page, 8'(k)}));
      for (int k = 0; k < n && k < wrQ.size(); k++)
         checkOutput({tag, ".oamData"}, 32'(wrQ[k]), 32'(8'(k) ^ memKey));
   endtask

   task automatic runTransfer(input string tag, input logic [7:0] page, input int trigPut,
                              input int gapMin, input int gapMax, input int injectAt,
                              input logic [7:0] injectPage, input int n, input int expHalt,
                              input int expWrites, input int expFirstRd);
      int trigTick;
      bit fin, injected, wr;
      if ((tickNo % 2) != trigPut) applyStimulus(int'($urandom_range(gapMax, gapMin)), 1'b0, 8'h00);
      clearObs();
      trigTick = tickNo;
      applyStimulus(int'($urandom_range(gapMax, gapMin)), 1'b1, page);
      fin = 0; injected = 0;
      for (int b = 0; b < 2 * n + 20 && !fin; b++) begin
         wr = (injectAt >= 0) && (wrQ.size() == injectAt) && !injected;
         applyStimulus(int'($urandom_range(gapMax, gapMin)), wr, injectPage);
         if (wr) injected = 1;
         if (lastRdy) fin = 1;
      end
      checkOutput({tag, ".terminated"}, 32'(fin), 32'd1);
      verifyTransfer(tag, page, n, expHalt, expWrites, expFirstRd, trigTick);
      checkOutput({tag, ".idleAddrHeld"}, 32'(oAddr), 32'({page, 8'(n - 1)}));
      checkOutput({tag, ".idleBusy"}, 32'(oBusy), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] pg;
      int tp, a;
      sel = 1'b0;
      memKey = 8'hA5;
      $display("[TB] OAM DMA register at %h, page size %0d", OAM_DMA_REG, OAM_BYTES);

      vecs[0] = '{8'h02, 0, -1, 8'h00, 513, 256, 2};
      vecs[1] = '{8'h02, 1, -1, 8'h00, 514, 256, 3};
      vecs[2] = '{8'h02, 0, 100, 8'h07, 513, 256, 2};
      vecs[3] = '{8'hFF, 1, 200, 8'h01, 514, 256, 3};

      doReset();
      @(negedge clk);
      checkOutput("reset.outputs", 32'({rdyA, rdA, addrA, oamA, wrA, busyA, doneA}),
                  32'({1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0}));
      checkOutput("reset.outputsSmall", 32'({rdyB, rdB, addrB, oamB, wrB, busyB, doneB}),
                  32'({1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0}));
      @(posedge clk); #1;

      for (int v = 0; v < 4; v++)
         runTransfer($sformatf("vec%0d", v), vecs[v].page, vecs[v].trigPut, 0, 0,
                     vecs[v].injectAt, vecs[v].injectPage, 256,
                     vecs[v].expHalt, vecs[v].expWrites, vecs[v].expFirstRd);

      // Reset while byte 37 is in flight, then a fresh transfer must restart at index 0.
      doReset();
      clearObs();
      applyStimulus(0, 1'b1, 8'h33);
      for (int b = 0; b < 200 && wrQ.size() < 37; b++) applyStimulus(0, 1'b0, 8'h00);
      checkOutput("midReset.reachedByte", 32'(wrQ.size()), 32'd37);
      cpu_ce = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cpu_ce = 1'b0;
      tickNo = 0;
      @(negedge clk);
      checkOutput("midReset.state", 32'({oRdy, oBusy, oDone, oWr, oRd}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
      @(posedge clk); #1;
      clearObs();
      repeat (4) applyStimulus(0, 1'b0, 8'h00);
      checkOutput("midReset.noWrites", 32'(wrQ.size()), 32'd0);
      checkOutput("midReset.noDone", 32'(doneCnt), 32'd0);
      runTransfer("restart", 8'h44, 0, 0, 0, -1, 8'h00, 256, 513, 256, 2);

      // Short transfers with sparse cpu_ce; expectations come from the timing rules.
      sel = 1'b1;
      doReset();
      runTransfer("small.gap2", 8'h5C, 0, 2, 2, -1, 8'h00, 4, 9, 4, 2);
      for (int r = 0; r < 8; r++) begin
         pg = 8'($urandom);
         tp = int'($urandom_range(1, 0));
         memKey = 8'($urandom);
         a = tp;
         runTransfer($sformatf("small.rand%0d", r), pg, tp, 0, 3, int'($urandom_range(3, 0)),
                     8'($urandom), 4, 1 + a + 2 * 4, 4, 2 + a);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences sprite OAM DMA, triggered by a CPU write to $4014.
- Halts the CPU and copies a 256-byte CPU page into PPU OAM. Each byte is one CPU-bus read followed by one OAM write.
- Sits between the CPU bus interface and the PPU OAM write port (oam_data_i / oam_data_wr).
- Owns the CPU bus for the duration of the transfer.

Parameters:
- NUM_BYTES, 256: bytes per transfer (1..256). The byte counter is 9 bits.
- ALIGN_EN, 1: 1 inserts one alignment cycle when the first read would land on a put cycle; 0 never aligns.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cpu_ce  in  1  one-clk pulse per CPU cycle; all state advances only on clk edges where cpu_ce=1
- reg_wr  in  1  CPU write strobe to $4014, qualified by cpu_ce
- reg_data  in  8  page number written to $4014
- dma_data_i  in  8  CPU-bus read data, valid on the cpu_ce edge that ends a read cycle
- cpu_rdy  out  1  0 halts the CPU
- dma_rd  out  1  DMA owns the bus for a read this CPU cycle
- dma_addr  out  16  read address {page, idx[7:0]}
- oam_data_o  out  8  byte to OAM
- oam_data_wr  out  1  one-clk OAM write strobe, coincident with cpu_ce
- busy  out  1  transfer in progress
- done  out  1  one-clk pulse after the last OAM write

Behaviour:
- Reset values: cpu_rdy=1, dma_rd=0, dma_addr=0, oam_data_o=0, oam_data_wr=0, busy=0, done=0.
- Internal state on reset: state=IDLE, idx=0, parity=GET.
- Parity: toggles on every cpu_ce, whatever the state (GET -> PUT -> GET ...).
- States:
  - IDLE: reg_wr && cpu_ce latches page, clears idx, sets busy -> HALT.
  - HALT: one CPU cycle, cpu_rdy=0. On cpu_ce: if ALIGN_EN and the next cycle is PUT -> ALIGN, else -> READ.
  - ALIGN: one idle CPU cycle, cpu_rdy=0 -> READ.
  - READ: dma_rd=1, dma_addr={page, idx[7:0]}. On cpu_ce: latch dma_data_i into oam_data_o -> WRITE.
  - WRITE: oam_data_wr = cpu_ce. On cpu_ce: idx+1. If idx==NUM_BYTES-1 -> IDLE with done=1, else -> READ.
- cpu_rdy=0 in every state except IDLE.
- In IDLE, cpu_rdy goes high on the clk edge that leaves WRITE.
- Total halt: 1 + align + 2*NUM_BYTES CPU cycles (513 or 514 for the default).
- dma_rd and dma_addr are registered and change only on cpu_ce edges.
- dma_addr holds its last value in IDLE.
- reg_wr while busy is ignored; the page does not change mid-transfer.
- idx arithmetic: idx[7:0] wraps within the page; it never carries into the page byte.
- rst mid-transfer: back to IDLE immediately, cpu_rdy=1, no further oam_data_wr, done not pulsed.
- cpu_ce=0: all outputs hold, except oam_data_wr and done, which are 0.

Optional Feature:
- Macro: OAM_DMA_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort && cpu_ce in READ or WRITE terminates after the current cycle: -> IDLE, cpu_rdy=1, busy=0.
  - An abort in WRITE still performs that write.
  - done is not pulsed. A sticky output aborted is set and cleared by the next reg_wr.
- When undefined: no abort port and no aborted output; a transfer always runs to completion.

Decomposition:
- Shared package ppu_pkg holds:
  - typedef enum dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}
  - OAM_DMA_REG = 16'h4014
  - OAM_BYTES = 256
  - typedef cpu_parity_t {GET, PUT}
- No sub-module. The parity flop and byte counter are inline.

Test Plan:
- Trigger page 0x02 on a GET-aligned cycle, ALIGN_EN=1 -> cpu_rdy low 513 cycles; 256 oam_data_wr pulses; dma_addr 0x0200..0x02FF; done one pulse.
- Trigger on a PUT-aligned cycle -> cpu_rdy low 514 cycles; first dma_rd appears 2 CPU cycles after HALT.
- Memory returns data = addr[7:0]^0xA5 -> OAM write k carries k^0xA5, in order, k=0..255.
- Second reg_wr (page 0x07) at byte 100 -> ignored; all addresses stay 0x02xx.
- rst asserted at byte 37 -> next clk: cpu_rdy=1, busy=0, no done. A new trigger then restarts at idx 0.
- NUM_BYTES=4, gaps of 2 clk between cpu_ce -> exactly 4 writes; outputs hold between cpu_ce pulses; done aligned with cpu_ce.
